// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-to-1 round-robin lane merge with per-lane FIFOs and a registered valid/ready output.
// Optional build macro SKIP_EMPTY_LANE_EN selects work-conserving lane search instead of strict order.
`default_nettype none

module mux_nx1_rr #(
   parameter int NUM_LANES  = 4,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_LANES*DATA_W-1:0]    in_data,
   input  logic [NUM_LANES-1:0]           in_valid,
   output logic [NUM_LANES-1:0]           in_ready,
   output logic [DATA_W-1:0]              out_data,
   output logic                           out_valid,
   output logic [$clog2(NUM_LANES)-1:0]   out_lane,
   input  logic                           out_ready
);

   localparam int SEL_W = $clog2(NUM_LANES);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [NUM_LANES-1:0]              push;
   logic [NUM_LANES-1:0]              pop;
   logic [NUM_LANES-1:0]              nonempty;
   logic [NUM_LANES-1:0][DATA_W-1:0]  head_w;

   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   load_lane;
   logic               load;
   logic               out_free;

   logic [DATA_W-1:0]  out_data_q;
   logic [SEL_W-1:0]   out_lane_q;
   logic               out_valid_q;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q;
      logic [PTR_W-1:0]  rd_ptr_q;
      logic [CNT_W-1:0]  cnt_q;

      // Ready depends on occupancy only, never on a same-cycle pop.
      assign in_ready[k] = (cnt_q != CNT_W'(FIFO_DEPTH));
      assign nonempty[k] = (cnt_q != '0);
      assign push[k]     = in_valid[k] & in_ready[k];
      assign pop[k]      = load & (load_lane == SEL_W'(k));
      assign head_w[k]   = mem_q[rd_ptr_q];

      always_ff @(posedge clk) begin
         if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (push[k]) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop[k])  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push[k], pop[k]})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: cnt_q <= cnt_q;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (push[k]) mem_q[wr_ptr_q] <= in_data[k*DATA_W +: DATA_W];
      end
   end

   assign out_free = ~out_valid_q | out_ready;

`ifdef SKIP_EMPTY_LANE_EN
   logic             found;
   logic [SEL_W:0]   scan_sum;
   logic [SEL_W-1:0] scan_idx;

   // Rotating priority search starting at sel; first non-empty lane wins.
   always_comb begin
      load_lane = sel_q;
      found     = 1'b0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         scan_sum = {1'b0, sel_q} + (SEL_W+1)'(i);
         if (scan_sum >= (SEL_W+1)'(NUM_LANES)) scan_sum = scan_sum - (SEL_W+1)'(NUM_LANES);
         scan_idx = scan_sum[SEL_W-1:0];
         if (!found && nonempty[scan_idx]) begin
            found     = 1'b1;
            load_lane = scan_idx;
         end
      end
      load = out_free & found;
   end
`else
   always_comb begin
      load_lane = sel_q;
      load      = out_free & nonempty[sel_q];
   end
`endif

   always_comb begin
      sel_d = sel_q;
      if (load) sel_d = (load_lane == SEL_W'(NUM_LANES - 1)) ? '0 : load_lane + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q       <= '0;
         out_data_q  <= '0;
         out_lane_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
         if (load) begin
            out_data_q  <= head_w[load_lane];
            out_lane_q  <= load_lane;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_lane  = out_lane_q;
   assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr: directed stimulus with a per-lane scoreboard for mux_nx1_rr (NUM_LANES=4).
`default_nettype none

module tb_mux_nx1_rr;

   localparam int NL = 4;
   localparam int DW = 8;
   localparam int FD = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NL*DW-1:0]  in_data;
   logic [NL-1:0]     in_valid;
   logic [NL-1:0]     in_ready;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic [1:0]        out_lane;
   logic              out_ready;

   mux_nx1_rr #(.NUM_LANES(NL), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_lane(out_lane),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int unsigned nxt [NL];
   logic [7:0]  base [NL];
   logic [NL-1:0] stream_mask;
   logic [7:0]  lane_q [NL][$];
   int          exp_lane;
   logic        seen_block;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qtotal();
      int s = 0;
      for (int k = 0; k < NL; k++) s += lane_q[k].size();
      return s;
   endfunction

   // Scoreboard: record accepted pushes, compare every accepted output.
   always @(negedge clk) begin
      if (reset) begin
         for (int k = 0; k < NL; k++) lane_q[k].delete();
         exp_lane = 0;
      end else begin
         if (out_valid && out_ready) begin
`ifndef SKIP_EMPTY_LANE_EN
            chk("sb_lane", 32'(out_lane), exp_lane);
            exp_lane = (exp_lane + 1) % NL;
`endif
            if (lane_q[out_lane].size() == 0) begin
               checks++;
               errors++;
               $error("FAIL sb_unexpected: observed lane %0d data %0h expected no output", out_lane, out_data);
            end else begin
               chk("sb_data", 32'(out_data), 32'(lane_q[out_lane].pop_front()));
            end
         end
         for (int k = 0; k < NL; k++) begin
            if (in_valid[k] && in_ready[k]) begin
               lane_q[k].push_back(in_data[k*DW +: DW]);
               nxt[k]++;
            end
         end
      end
   end

   task automatic drive_stream();
      for (int k = 0; k < NL; k++) begin
         if (stream_mask[k]) begin
            in_valid[k]          = 1'b1;
            in_data[k*DW +: DW]  = base[k] + 8'(nxt[k]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive_stream();
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      in_valid    = '0;
      stream_mask = '0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < NL; k++) nxt[k] = 0;
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      while (out_valid !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_wait"}, 32'(out_valid), 1);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((qtotal() != 0 || out_valid) && n < max) begin
         tick();
         n++;
      end
      chk("drain_left", qtotal(), 0);
      chk("drain_valid", 32'(out_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      in_valid    = '0;
      in_data     = '0;
      out_ready   = 1'b0;
      stream_mask = '0;
      for (int k = 0; k < NL; k++) begin
         nxt[k]  = 0;
         base[k] = 8'(k * 16);
      end
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_lane", 32'(out_lane), 0);
      chk("rst_ready", 32'(in_ready), 32'hF);
      chk("rst_sel", 32'(dut.sel_q), 0);
      reset = 1'b0;

      repeat (10) begin
         tick();
         chk("idle_valid", 32'(out_valid), 0);
         chk("idle_ready", 32'(in_ready), 32'hF);
         chk("idle_sel", 32'(dut.sel_q), 0);
      end

`ifndef SKIP_EMPTY_LANE_EN
      // Lane 1 word must wait behind lane 0.
      out_ready        = 1'b1;
      in_valid[1]      = 1'b1;
      in_data[15:8]    = 8'h10;
      tick();
      in_valid = '0;
      tick();
      tick();
      chk("order_none_early", 32'(out_valid), 0);
      in_valid[0]   = 1'b1;
      in_data[7:0]  = 8'h00;
      tick();
      in_valid = '0;
      chk("order_latency", 32'(out_valid), 0);
      tick();
      chk("order_v0", 32'(out_valid), 1);
      chk("order_d0", 32'(out_data), 32'h00);
      chk("order_l0", 32'(out_lane), 0);
      tick();
      chk("order_v1", 32'(out_valid), 1);
      chk("order_d1", 32'(out_data), 32'h10);
      chk("order_l1", 32'(out_lane), 1);
      tick();
      chk("order_idle", 32'(out_valid), 0);
`endif

      // Full streaming on all lanes.
      do_reset();
      out_ready   = 1'b1;
      stream_mask = '1;
      drive_stream();
      wait_valid(10, "stream_first");
      chk("stream_first_data", 32'(out_data), 32'h00);
      seen_block = 1'b0;
      repeat (16) begin
         tick();
         chk("stream_gapless", 32'(out_valid), 1);
         if (in_ready != 4'hF) seen_block = 1'b1;
      end
      chk("stream_ready_drop", 32'(seen_block), 1);
      stream_mask = '0;
      in_valid    = '0;
      drain(200);

      // Backpressure: head word A5 must hold while lanes fill.
      do_reset();
      out_ready   = 1'b0;
      base[0]     = 8'hA5;
      stream_mask = '1;
      drive_stream();
      wait_valid(10, "bp_first");
      chk("bp_first_data", 32'(out_data), 32'hA5);
      repeat (6) begin
         tick();
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(out_data), 32'hA5);
         chk("bp_lane", 32'(out_lane), 0);
         chk("bp_sel", 32'(dut.sel_q), 1);
      end
      chk("bp_full", 32'(in_ready), 0);
      stream_mask = '0;
      in_valid    = '0;
      out_ready   = 1'b1;
      drain(200);
      base[0] = 8'h00;

      // Reset with words buffered.
      do_reset();
      out_ready = 1'b0;
      in_valid  = 4'b0111;
      in_data   = 32'h0003_0201;
      tick();
      in_valid = '0;
      tick();
      chk("mid_prefill", 32'(out_valid), 1);
      reset = 1'b1;
      tick();
      chk("mid_valid", 32'(out_valid), 0);
      chk("mid_ready", 32'(in_ready), 32'hF);
      reset        = 1'b0;
      out_ready    = 1'b1;
      in_valid[0]  = 1'b1;
      in_data[7:0] = 8'h5A;
      tick();
      in_valid = '0;
      wait_valid(5, "mid_post");
      chk("mid_post_data", 32'(out_data), 32'h5A);
      chk("mid_post_lane", 32'(out_lane), 0);
      drain(50);

`ifdef SKIP_EMPTY_LANE_EN
      // Only lane 2 active: outputs must not stall on empty lanes.
      do_reset();
      out_ready      = 1'b1;
      in_valid[2]    = 1'b1;
      in_data[23:16] = 8'h33;
      tick();
      in_data[23:16] = 8'h34;
      tick();
      in_valid = '0;
      chk("skip_v0", 32'(out_valid), 1);
      chk("skip_d0", 32'(out_data), 32'h33);
      chk("skip_l0", 32'(out_lane), 2);
      tick();
      chk("skip_v1", 32'(out_valid), 1);
      chk("skip_d1", 32'(out_data), 32'h34);
      chk("skip_l1", 32'(out_lane), 2);
      tick();
      chk("skip_sel", 32'(dut.sel_q), 3);
      chk("skip_idle", 32'(out_valid), 0);
      drain(20);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
